// File: rtl/mru_tracker_param_pkg.sv
// Shared types, constants and helpers for the recency tracker (package mru_pkg).
// MRU_STATS_EN (when defined) enables the hit/miss/evict statistics counters.
package mru_pkg;

  typedef enum logic {MRU = 1'b0, LRU = 1'b1} policy_e;

  localparam int STAT_W = 16;

  // True only for exactly one bit set; any X/Z bit rejects the vector outright.
  function automatic logic onehot_ok(input logic [31:0] v);
    if (^v === 1'bx) return 1'b0;
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/mru_tracker_param_if.sv
// Request/residency bundle between panel input logic and the tracker.
// MRU_STATS_EN adds the saturating statistics outputs.
interface mru_tracker_param_if
  import mru_pkg::*;
#(
  parameter int N_CH = 5
);
  localparam int IDX_W = $clog2(N_CH);

  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  resident;
  logic [IDX_W-1:0] mru_idx;
  logic             mru_valid;
  logic             evict_vld;
  logic [IDX_W-1:0] evict_idx;
  logic             req_err;
`ifdef MRU_STATS_EN
  logic [STAT_W-1:0] hit_cnt;
  logic [STAT_W-1:0] miss_cnt;
  logic [STAT_W-1:0] evict_cnt;

  modport master (output req,
                  input  resident, mru_idx, mru_valid, evict_vld, evict_idx, req_err,
                  input  hit_cnt, miss_cnt, evict_cnt);
  modport slave  (input  req,
                  output resident, mru_idx, mru_valid, evict_vld, evict_idx, req_err,
                  output hit_cnt, miss_cnt, evict_cnt);
`else
  modport master (output req,
                  input  resident, mru_idx, mru_valid, evict_vld, evict_idx, req_err);
  modport slave  (input  req,
                  output resident, mru_idx, mru_valid, evict_vld, evict_idx, req_err);
`endif
endinterface

// File: rtl/mru_tracker_param_enc.sv
// Request classifier: flags idle / clean one-hot requests and encodes the channel index.
module mru_onehot_enc
  import mru_pkg::*;
#(
  parameter int N_CH = 5
) (
  input  logic [N_CH-1:0]         req,
  output logic                    is_zero,
  output logic                    is_onehot,
  output logic [$clog2(N_CH)-1:0] idx
);
  localparam int IDX_W = $clog2(N_CH);

  logic has_x;

  assign has_x     = (^req === 1'bx);
  assign is_zero   = !has_x && (req == '0);
  assign is_onehot = onehot_ok(32'(req));

  // idx is only meaningful when is_onehot is set.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mru_tracker_param.sv
// Recency tracker: keeps up to CAPACITY resident channels in a recency stack (slot 0 newest)
// and evicts per POLICY on a full miss. MRU_STATS_EN adds saturating hit/miss/evict counters.
module mru_tracker_param
  import mru_pkg::*;
#(
  parameter int      N_CH     = 5,
  parameter int      CAPACITY = 4,
  parameter policy_e POLICY   = MRU
) (
  input logic                clk,
  input logic                rst,
  mru_tracker_param_if.slave bus
);
  localparam int IDX_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(CAPACITY + 1);

  logic [IDX_W-1:0] stk_reg  [CAPACITY];
  logic [IDX_W-1:0] stk_next [CAPACITY];
  logic [CNT_W-1:0] count_reg, count_next;
  logic [N_CH-1:0]  resident_reg, resident_next;
  logic             evict_vld_reg, evict_vld_next;
  logic [IDX_W-1:0] evict_idx_reg, evict_idx_next;
  logic             req_err_reg, req_err_next;

  logic             req_zero, req_onehot;
  logic [IDX_W-1:0] req_idx;
  logic             hit, do_push;
  logic [CNT_W-1:0] hit_pos, shift_lim;
  logic [IDX_W-1:0] victim;

  mru_onehot_enc #(.N_CH(N_CH)) u_enc (
    .req       (bus.req),
    .is_zero   (req_zero),
    .is_onehot (req_onehot),
    .idx       (req_idx)
  );

  always_comb begin
    hit            = 1'b0;
    hit_pos        = '0;
    do_push        = 1'b0;
    shift_lim      = '0;
    victim         = '0;
    count_next     = count_reg;
    resident_next  = resident_reg;
    evict_vld_next = 1'b0;
    evict_idx_next = '0;
    req_err_next   = !req_zero && !req_onehot;

    for (int p = 0; p < CAPACITY; p++) begin
      if ((CNT_W'(p) < count_reg) && (stk_reg[p] == req_idx)) begin
        hit     = 1'b1;
        hit_pos = CNT_W'(p);
      end
    end

    // Every accepted request ends with the channel in slot 0; shift_lim selects how many
    // slots below it slide down by one.
    if (req_onehot) begin
      do_push = 1'b1;
      if (hit) begin
        shift_lim = hit_pos;
      end else if (count_reg != CNT_W'(CAPACITY)) begin
        shift_lim              = count_reg;
        count_next             = count_reg + 1'b1;
        resident_next[req_idx] = 1'b1;
      end else begin
        victim                 = (POLICY == MRU) ? stk_reg[0] : stk_reg[CAPACITY-1];
        shift_lim              = (POLICY == MRU) ? '0 : CNT_W'(CAPACITY - 1);
        resident_next[victim]  = 1'b0;
        resident_next[req_idx] = 1'b1;
        evict_vld_next         = 1'b1;
        evict_idx_next         = victim;
      end
    end
  end

  assign stk_next[0] = do_push ? req_idx : stk_reg[0];

  genvar gi;
  generate
    for (gi = 1; gi < CAPACITY; gi++) begin : g_shift
      assign stk_next[gi] = (do_push && (CNT_W'(gi) <= shift_lim)) ? stk_reg[gi-1] : stk_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < CAPACITY; p++) stk_reg[p] <= '0;
      count_reg     <= '0;
      resident_reg  <= '0;
      evict_vld_reg <= 1'b0;
      evict_idx_reg <= '0;
      req_err_reg   <= 1'b0;
    end else begin
      for (int p = 0; p < CAPACITY; p++) stk_reg[p] <= stk_next[p];
      count_reg     <= count_next;
      resident_reg  <= resident_next;
      evict_vld_reg <= evict_vld_next;
      evict_idx_reg <= evict_idx_next;
      req_err_reg   <= req_err_next;
    end
  end

  assign bus.resident  = resident_reg;
  assign bus.mru_valid = (count_reg != '0);
  assign bus.mru_idx   = (count_reg != '0) ? stk_reg[0] : '0;
  assign bus.evict_vld = evict_vld_reg;
  assign bus.evict_idx = evict_idx_reg;
  assign bus.req_err   = req_err_reg;

`ifdef MRU_STATS_EN
  logic [STAT_W-1:0] hit_cnt_reg, miss_cnt_reg, evict_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_reg   <= '0;
      miss_cnt_reg  <= '0;
      evict_cnt_reg <= '0;
    end else begin
      if (req_onehot && hit && (hit_cnt_reg != '1))   hit_cnt_reg   <= hit_cnt_reg + 1'b1;
      if (req_onehot && !hit && (miss_cnt_reg != '1)) miss_cnt_reg  <= miss_cnt_reg + 1'b1;
      if (evict_vld_next && (evict_cnt_reg != '1))    evict_cnt_reg <= evict_cnt_reg + 1'b1;
    end
  end

  assign bus.hit_cnt   = hit_cnt_reg;
  assign bus.miss_cnt  = miss_cnt_reg;
  assign bus.evict_cnt = evict_cnt_reg;
`endif

endmodule
